key_pwd_lock: RTL

- Downstream consumer of the 4x4 matrix keypad scanner. Takes one registered 4-bit key code per key_vld pulse and drives a code-lock controller.
- Collects DIGITS decimal digits with backspace and clear, compares the entry against a stored password on ENTER, and reports pass or fail.
- Counts consecutive failures and locks the keypad out after MAX_FAIL failures.
- Supports changing the password while in the pass state. The BCD entry buffer drives the segment-display stage.

---
 rtl/key_pkg.sv | 23 ++
 rtl/lock_timer.sv | 27 ++
 rtl/key_pwd_lock.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keypad code-lock: key codes, controller states
// and the display blank nibble.
package key_pkg;

    localparam logic [3:0] KEY_BSP      = 4'd10;
    localparam logic [3:0] KEY_CLR      = 4'd11;
    localparam logic [3:0] KEY_SET      = 4'd12;
    localparam logic [3:0] KEY_ENT      = 4'd15;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INPUT,
        ST_PASS,
        ST_FAIL,
        ST_LOCK
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the pass/fail display and lockout
// intervals; done flags the final cycle of an interval.
module lock_timer #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/key_pwd_lock.sv
// Code-lock controller fed by the keypad scanner: digit entry with
// backspace/clear, password compare, failure lockout and password change.
module key_pwd_lock #(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] PWD_INIT  = 16'h1234,
    parameter int                  MAX_FAIL  = 3,
    parameter int                  TIME_SHOW = 50_000_000,
    parameter int                  TIME_LOCK = 250_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key_in,
    input  logic                key_vld,
    output logic [4*DIGITS-1:0] disp_data,
    output logic [2:0]          disp_cnt,
    output logic                pwd_ok,
    output logic                pwd_err,
    output logic                locked,
    output logic                set_mode
);
    import key_pkg::*;

    localparam int W  = 4 * DIGITS;
    localparam int TW = 28;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [W-1:0]  BLANK_ALL = {DIGITS{BLANK_NIBBLE}};
    localparam logic [TW-1:0] SHOW_LD   = TW'(TIME_SHOW - 1);
    localparam logic [TW-1:0] LOCK_LD   = TW'(TIME_LOCK - 1);

    state_t        state, state_n;
    logic [W-1:0]  data_n, pwd, pwd_n;
    logic [2:0]    cnt_n;
    logic [FW-1:0] fail_cnt, fail_n;
    logic          set_n;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;

    lock_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // NOTE: every comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_n = state;
        data_n  = disp_data;
        cnt_n   = disp_cnt;
        pwd_n   = pwd;
        fail_n  = fail_cnt;
        set_n   = set_mode;
        unique case (state)
            ST_IDLE: begin
                if (key_vld && is_digit(key_in)) begin
                    data_n  = {BLANK_ALL[W-1:4], key_in};
                    cnt_n   = 3'd1;
                    state_n = ST_INPUT;
                end
            end
            ST_INPUT: begin
                if (key_vld) begin
                    if (is_digit(key_in)) begin
                        if (disp_cnt < 3'(DIGITS)) begin
                            data_n = {disp_data[W-5:0], key_in};
                            cnt_n  = disp_cnt + 3'd1;
                        end
                    end else if (key_in == KEY_BSP) begin
                        data_n = {BLANK_NIBBLE, disp_data[W-1:4]};
                        cnt_n  = disp_cnt - 3'd1;
                        if (disp_cnt == 3'd1)
                            state_n = ST_IDLE;
                    end else if (key_in == KEY_CLR) begin
                        data_n  = BLANK_ALL;
                        cnt_n   = 3'd0;
                        state_n = ST_IDLE;
                    end else if (key_in == KEY_ENT && disp_cnt == 3'(DIGITS)) begin
                        if (set_mode) begin
                            pwd_n   = disp_data;
                            set_n   = 1'b0;
                            fail_n  = '0;
                            state_n = ST_PASS;
                        end else if (disp_data == pwd) begin
                            fail_n  = '0;
                            state_n = ST_PASS;
                        end else begin
                            fail_n  = fail_cnt + FW'(1);
                            state_n = ST_FAIL;
                        end
                    end
                end
            end
            ST_PASS: begin
                // Expiry outranks a same-cycle key.
                if (tmr_done || (key_vld && key_in == KEY_SET)) begin
                    if (!tmr_done)
                        set_n = 1'b1;
                    data_n  = BLANK_ALL;
                    cnt_n   = 3'd0;
                    state_n = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (tmr_done) begin
                    data_n  = BLANK_ALL;
                    cnt_n   = 3'd0;
                    state_n = (fail_cnt == FW'(MAX_FAIL)) ? ST_LOCK : ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (tmr_done) begin
                    fail_n  = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Any state change reloads the timer; untimed states park it at zero.
    always_comb begin
        tmr_load = (state_n != state);
        unique case (state_n)
            ST_PASS, ST_FAIL: tmr_val = SHOW_LD;
            ST_LOCK:          tmr_val = LOCK_LD;
            default:          tmr_val = '0;
        endcase
    end

    // NOTE: the password register is a plain register, not a memory, so it
    // takes its PWD_INIT value on reset like the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            disp_data <= BLANK_ALL;
            disp_cnt  <= 3'd0;
            pwd       <= PWD_INIT;
            fail_cnt  <= '0;
            set_mode  <= 1'b0;
            pwd_ok    <= 1'b0;
            pwd_err   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            disp_data <= data_n;
            disp_cnt  <= cnt_n;
            pwd       <= pwd_n;
            fail_cnt  <= fail_n;
            set_mode  <= set_n;
            pwd_ok    <= (state_n == ST_PASS);
            pwd_err   <= (state_n == ST_FAIL);
            locked    <= (state_n == ST_LOCK);
        end
    end

endmodule
